// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage feeding the 8-bit ALU, with a per-register scoreboard for in-flight writes.
// Optional feature: define WB_BYPASS_EN to forward writeback data and clear its hazard in the same cycle.
module operand_fetch #(
  parameter int DW    = 8,
  parameter int NREGS = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [15:0]              inst,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [DW-1:0]            wb_data,
  output logic [7:0]               opcode,
  output logic [DW-1:0]            rdataA,
  output logic [DW-1:0]            rdataB,
  output logic                     issue_valid,
  output logic                     issue_wen,
  output logic [$clog2(NREGS)-1:0] issue_dest,
  output logic                     illegal
);

  localparam int AW = $clog2(NREGS);

  logic [DW-1:0]    regs_q [NREGS];
  logic [DW-1:0]    regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  logic [7:0]    opcode_q, opcode_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic          issue_valid_q, issue_valid_d;
  logic          issue_wen_q, issue_wen_d;
  logic [AW-1:0] issue_dest_q, issue_dest_d;
  logic          illegal_q, illegal_d;

  logic [3:0]    hi_s, ext_s;
  logic [AW-1:0] rd_s, rs_s;
  logic [DW-1:0] rd_val_s, rs_val_s;
  logic [NREGS-1:0] pend_eff_s;
  logic          legal_s, rd_use_s, rs_use_s, wen_s, hazard_s, accept_s;
  logic [7:0]    op_s;
  logic [DW-1:0] a_s, b_s;

  function automatic logic in_imm_set(input logic [3:0] n);
    case (n)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign hi_s  = inst[15:12];
  assign rd_s  = inst[11:8];
  assign ext_s = inst[7:4];
  assign rs_s  = inst[3:0];

  // Register-file read ports and the pending view used by the hazard check
  always_comb begin
`ifdef WB_BYPASS_EN
    rd_val_s   = (wb_en && (wb_addr == rd_s)) ? wb_data : regs_q[rd_s];
    rs_val_s   = (wb_en && (wb_addr == rs_s)) ? wb_data : regs_q[rs_s];
    pend_eff_s = pend_q;
    if (wb_en) begin
      pend_eff_s[wb_addr] = 1'b0;
    end else begin
      pend_eff_s = pend_q;
    end
`else
    rd_val_s   = regs_q[rd_s];
    rs_val_s   = regs_q[rs_s];
    pend_eff_s = pend_q;
`endif
  end

  // Instruction decode: operand selection, register usage and write intent
  always_comb begin
    legal_s  = 1'b0;
    rd_use_s = 1'b0;
    rs_use_s = 1'b0;
    wen_s    = 1'b0;
    op_s     = 8'h00;
    a_s      = '0;
    b_s      = '0;
    case (hi_s)
      4'h0: begin
        if (in_imm_set(ext_s)) begin
          legal_s  = 1'b1;
          op_s     = {4'h0, ext_s};
          a_s      = rd_val_s;
          b_s      = rs_val_s;
          rd_use_s = 1'b1;
          rs_use_s = 1'b1;
          wen_s    = (ext_s != 4'hB);
        end else begin
          legal_s  = 1'b0;
        end
      end
      4'h8: begin
        legal_s  = 1'b1;
        op_s     = {4'h8, ext_s};
        a_s      = rd_val_s;
        rd_use_s = 1'b1;
        wen_s    = 1'b1;
        if (ext_s == 4'h4) begin
          b_s      = rs_val_s;
          rs_use_s = 1'b1;
        end else begin
          b_s      = '0;
          rs_use_s = 1'b0;
        end
      end
      4'hF: begin
        legal_s = 1'b1;
        op_s    = 8'hF0;
        b_s     = DW'(inst[7:0]);
        wen_s   = 1'b1;
      end
      default: begin
        if (in_imm_set(hi_s)) begin
          legal_s  = 1'b1;
          op_s     = {4'h0, hi_s};
          a_s      = rd_val_s;
          b_s      = DW'(inst[7:0]);
          rd_use_s = 1'b1;
          wen_s    = (hi_s != 4'hB);
        end else begin
          legal_s  = 1'b0;
        end
      end
    endcase
  end

  // The destination counts as a dependency too, so writes retire in order per register
  assign hazard_s   = ((rd_use_s | wen_s) & pend_eff_s[rd_s]) | (rs_use_s & pend_eff_s[rs_s]);
  assign accept_s   = inst_valid & ~hazard_s;
  assign inst_ready = ~(inst_valid & hazard_s);

  // Next state: scoreboard (set beats clear), register array and issue bundle
  always_comb begin
    pend_d = pend_q;
    regs_d = regs_q;
    if (wb_en) begin
      pend_d[wb_addr] = 1'b0;
      regs_d[wb_addr] = wb_data;
    end else begin
      pend_d = pend_q;
    end
    if (accept_s && legal_s && wen_s) begin
      pend_d[rd_s] = 1'b1;
    end else begin
      pend_d = pend_d;
    end

    opcode_d      = 8'h00;
    rdata_a_d     = '0;
    rdata_b_d     = '0;
    issue_valid_d = 1'b0;
    issue_wen_d   = 1'b0;
    issue_dest_d  = '0;
    illegal_d     = 1'b0;
    if (accept_s && legal_s) begin
      opcode_d      = op_s;
      rdata_a_d     = a_s;
      rdata_b_d     = b_s;
      issue_valid_d = 1'b1;
      issue_wen_d   = wen_s;
      issue_dest_d  = rd_s;
    end else if (accept_s) begin
      illegal_d     = 1'b1;
    end else begin
      illegal_d     = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q        <= '0;
      opcode_q      <= 8'h00;
      rdata_a_q     <= '0;
      rdata_b_q     <= '0;
      issue_valid_q <= 1'b0;
      issue_wen_q   <= 1'b0;
      issue_dest_q  <= '0;
      illegal_q     <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      pend_q        <= pend_d;
      opcode_q      <= opcode_d;
      rdata_a_q     <= rdata_a_d;
      rdata_b_q     <= rdata_b_d;
      issue_valid_q <= issue_valid_d;
      issue_wen_q   <= issue_wen_d;
      issue_dest_q  <= issue_dest_d;
      illegal_q     <= illegal_d;
    end
  end

  assign opcode      = opcode_q;
  assign rdataA      = rdata_a_q;
  assign rdataB      = rdata_b_q;
  assign issue_valid = issue_valid_q;
  assign issue_wen   = issue_wen_q;
  assign issue_dest  = issue_dest_q;
  assign illegal     = illegal_q;

endmodule
